// File: rtl/soc_fpga_ram_loader.sv
// rtl/soc_fpga_ram_loader.sv - byte-stream RAM loader with sum-based readback verify
// Packs bytes little-endian into words, writes them from address 0, then re-reads and compares sums.
module soc_fpga_ram_loader #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 PortAClk,
    input  logic                 PortAReset,
    input  logic                 Start,
    input  logic [ADDRWIDTH:0]   WordCount,
    input  logic                 Abort,
    input  logic [7:0]           ByteIn,
    input  logic                 ByteValid,
    output logic                 ByteReady,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass
);

    localparam int BPW = DATAWIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDRWIDTH:0] MEMDEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_VRD,
        S_VCAP,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ADDRWIDTH-1:0] last_idx;
    logic [ADDRWIDTH-1:0] idx;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [BCW-1:0]       byte_cnt;
    logic [DATAWIDTH-1:0] word_buf;
    logic [DATAWIDTH-1:0] wr_sum;
    logic [DATAWIDTH-1:0] rd_sum;
    logic [DATAWIDTH-1:0] rd_sum_nxt;
    logic                 pass_q;
    logic [ADDRWIDTH:0]   n_clamp;
    logic                 last_byte;
    logic                 last_word;

    assign n_clamp    = (WordCount > MEMDEPTH) ? MEMDEPTH : WordCount;
    assign last_byte  = (byte_cnt == BCW'(BPW - 1));
    assign last_word  = (idx == last_idx);
    assign rd_sum_nxt = rd_sum + RamDataOut;
    assign RamDataIn  = word_buf;
    assign Pass       = pass_q;

    always_comb begin
        state_nxt      = state;
        ByteReady      = (state == S_LOAD);
        RamWriteEnable = (state == S_WRITE);
        Busy           = (state != S_IDLE);
        Done           = (state == S_DONE);
        // Address is driven live only while it matters; otherwise it parks on the last used value.
        RamAddr        = ((state == S_WRITE) || (state == S_VRD)) ? idx : addr_q;
        case (state)
            S_IDLE:  if (Start) state_nxt = (n_clamp == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (ByteValid && last_byte) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_word ? S_VRD : S_LOAD;
            S_VRD:   state_nxt = S_VCAP;
            S_VCAP:  state_nxt = last_word ? S_DONE : S_VRD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (Abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge PortAClk) begin
        if (PortAReset) begin
            state    <= S_IDLE;
            last_idx <= '0;
            idx      <= '0;
            addr_q   <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            wr_sum   <= '0;
            rd_sum   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (Abort) begin
                byte_cnt <= '0;
                pass_q   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Start) begin
                            last_idx <= ADDRWIDTH'(n_clamp - 1'b1);
                            idx      <= '0;
                            addr_q   <= '0;
                            byte_cnt <= '0;
                            wr_sum   <= '0;
                            rd_sum   <= '0;
                            // An empty load trivially verifies.
                            pass_q   <= (n_clamp == '0);
                        end
                    end
                    S_LOAD: begin
                        if (ByteValid) begin
                            word_buf[8*byte_cnt +: 8] <= ByteIn;
                            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                        end
                    end
                    S_WRITE: begin
                        wr_sum <= wr_sum + word_buf;
                        addr_q <= idx;
                        idx    <= last_word ? '0 : idx + 1'b1;
                    end
                    S_VRD: addr_q <= idx;
                    S_VCAP: begin
                        rd_sum <= rd_sum_nxt;
                        if (last_word) pass_q <= (rd_sum_nxt == wr_sum);
                        else           idx    <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_soc_fpga_ram_loader.sv
// tb/tb_soc_fpga_ram_loader.sv - directed self-checking bench for soc_fpga_ram_loader
module tb_soc_fpga_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  word_count;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic        busy;
    logic        done;
    logic        pass;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    soc_fpga_ram_loader #(.DATAWIDTH(32), .ADDRWIDTH(4)) dut (
        .PortAClk(clk), .PortAReset(rst), .Start(start), .WordCount(word_count),
        .Abort(abort), .ByteIn(byte_in), .ByteValid(byte_valid), .ByteReady(byte_ready),
        .RamAddr(ram_addr), .RamDataIn(ram_din), .RamWriteEnable(ram_we),
        .RamDataOut(ram_dout), .Busy(busy), .Done(done), .Pass(pass)
    );

    // RAM model with one-edge read latency and optional corruption of address 1
    logic [31:0] mem [16];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr] ^ ((corrupt && ram_addr == 4'd1) ? 32'd1 : 32'd0);
    end

    int          cyc = 0;
    int          nwr = 0;
    int          ndone = 0;
    int          done_edge = 0;
    int          rdy_we = 0;
    logic        pass_at_done = 1'b0;
    logic [3:0]  wa [64];
    logic [31:0] wd [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            wa[nwr] <= ram_addr;
            wd[nwr] <= ram_din;
            nwr     <= nwr + 1;
            if (byte_ready) rdy_we <= rdy_we + 1;
        end
        if (done) begin
            ndone        <= ndone + 1;
            pass_at_done <= pass;
            done_edge    <= cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [4:0] wc);
        start      = 1'b1;
        word_count = wc;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        int k = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) check("byte_ready_timeout", 64'(k), 64'd0);
        step();
        acc = cyc;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            step();
            k++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    int acc, t0, wb, db, rb;

    initial begin
        rst = 1'b1;
        start = 1'($urandom); abort = 1'($urandom); byte_valid = 1'($urandom);
        byte_in = 8'($urandom); word_count = 5'($urandom);
        step();
        start = 1'($urandom); byte_valid = 1'($urandom);
        step();
        check("reset_flags", {59'd0, byte_ready, ram_we, busy, done, pass}, 64'd0);
        check("reset_addr", 64'(ram_addr), 64'd0);
        check("reset_wdata", 64'(ram_din), 64'd0);
        rst = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'd0; word_count = 5'd0;
        step();
        start_load(5'd3);
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(byte_ready), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle0", 64'(busy), 64'd0);

        // Nominal two-word load
        wb = nwr; db = ndone;
        start_load(5'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1), acc);
            if (i == 0) t0 = acc;
        end
        byte_valid = 1'b0;
        wait_idle();
        check("nom_nwr", 64'(nwr - wb), 64'd2);
        check("nom_a0", 64'(wa[wb]), 64'd0);
        check("nom_d0", 64'(wd[wb]), 64'h04030201);
        check("nom_a1", 64'(wa[wb+1]), 64'd1);
        check("nom_d1", 64'(wd[wb+1]), 64'h08070605);
        check("nom_ndone", 64'(ndone - db), 64'd1);
        check("nom_pass_at_done", 64'(pass_at_done), 64'd1);
        check("nom_latency", 64'(done_edge - t0), 64'd14);
        check("nom_pass_held", 64'(pass), 64'd1);

        // Readback corruption
        corrupt = 1'b1;
        wb = nwr; db = ndone;
        start_load(5'd2);
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), acc);
        byte_valid = 1'b0;
        wait_idle();
        corrupt = 1'b0;
        check("cor_nwr", 64'(nwr - wb), 64'd2);
        check("cor_ndone", 64'(ndone - db), 64'd1);
        check("cor_pass_at_done", 64'(pass_at_done), 64'd0);
        check("cor_pass_held", 64'(pass), 64'd0);

        // Stalled stream with a stray Start mid-load
        wb = nwr; db = ndone; rb = rdy_we;
        start_load(5'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1), acc);
            byte_valid = 1'b0;
            if (i == 2) begin
                start      = 1'b1;
                word_count = 5'd5;
            end
            step();
            start = 1'b0;
        end
        wait_idle();
        check("stall_nwr", 64'(nwr - wb), 64'd2);
        check("stall_a0", 64'(wa[wb]), 64'd0);
        check("stall_d0", 64'(wd[wb]), 64'h04030201);
        check("stall_a1", 64'(wa[wb+1]), 64'd1);
        check("stall_d1", 64'(wd[wb+1]), 64'h08070605);
        check("stall_ready_in_write", 64'(rdy_we - rb), 64'd0);
        check("stall_ndone", 64'(ndone - db), 64'd1);
        check("stall_pass", 64'(pass_at_done), 64'd1);

        // Abort after six bytes
        wb = nwr; db = ndone;
        start_load(5'd2);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), acc);
        abort = 1'b1;
        byte_valid = 1'b0;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pass", 64'(pass), 64'd0);
        check("abort_ready", 64'(byte_ready), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check("abort_nwr", 64'(nwr - wb), 64'd1);
        check("abort_a0", 64'(wa[wb]), 64'd0);
        check("abort_d0", 64'(wd[wb]), 64'h04030201);
        check("abort_ndone", 64'(ndone - db), 64'd0);

        // WordCount = 0
        wb = nwr; db = ndone;
        start_load(5'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_pass", 64'(pass), 64'd1);
        check("zero_busy", 64'(busy), 64'd1);
        step();
        check("zero_done_fall", 64'(done), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);
        check("zero_nwr", 64'(nwr - wb), 64'd0);
        check("zero_ndone", 64'(ndone - db), 64'd1);

        // WordCount = 20 clamps to the 16-word RAM
        wb = nwr; db = ndone;
        start_load(5'd20);
        for (int i = 0; i < 64; i++) send_byte(8'(i), acc);
        byte_valid = 1'b0;
        wait_idle();
        check("clamp_nwr", 64'(nwr - wb), 64'd16);
        check("clamp_d0", 64'(wd[wb]), 64'h03020100);
        check("clamp_a15", 64'(wa[wb+15]), 64'd15);
        check("clamp_d15", 64'(wd[wb+15]), 64'h3F3E3D3C);
        check("clamp_ndone", 64'(ndone - db), 64'd1);
        check("clamp_pass", 64'(pass_at_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
